// File: rtl/lcd_64_to_32_bits_adapter_core.sv
// Avalon-ST width adapter: 64-bit input beats split into 32-bit output words, high half first.
// Short EOP beats (empty >= 4) collapse to a single word carrying the residual empty count.
module lcd_64_to_32_bits_adapter_core #(
   parameter int USE_PACKETS = 1,
   parameter int ERROR_WIDTH = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [63:0]            in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_startofpacket,
   input  logic                   in_endofpacket,
   input  logic [2:0]             in_empty,
   input  logic [ERROR_WIDTH-1:0] in_error,
   output logic [31:0]            out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_startofpacket,
   output logic                   out_endofpacket,
   output logic [1:0]             out_empty,
   output logic [ERROR_WIDTH-1:0] out_error
);

   typedef enum logic [1:0] {S_EMPTY, S_HIGH, S_LOW} state_t;

   localparam bit PKT = (USE_PACKETS != 0);

   state_t                 state, state_nxt;
   logic [63:0]            hold_data;
   logic                   hold_sop, hold_eop, hold_single;
   logic [2:0]             hold_empty;
   logic [ERROR_WIDTH-1:0] hold_err;
   logic                   last_word, capture;

   // The word now on the output is the last one of the held beat; once it
   // transfers the next beat may be captured in the same cycle.
   always_comb begin
      last_word = (state == S_LOW) || ((state == S_HIGH) && hold_single);
      in_ready  = (state == S_EMPTY) || (out_ready && last_word);
      capture   = in_valid && in_ready;
      state_nxt = state;
      unique case (state)
         S_EMPTY: if (in_valid) state_nxt = S_HIGH;
         S_HIGH:  if (out_ready) state_nxt = hold_single ? (in_valid ? S_HIGH : S_EMPTY) : S_LOW;
         S_LOW:   if (out_ready) state_nxt = in_valid ? S_HIGH : S_EMPTY;
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_comb begin
      out_valid         = 1'b0;
      out_data          = '0;
      out_startofpacket = 1'b0;
      out_endofpacket   = 1'b0;
      out_empty         = '0;
      out_error         = '0;
      unique case (state)
         S_HIGH: begin
            out_valid         = 1'b1;
            out_data          = hold_data[63:32];
            out_startofpacket = hold_sop;
            out_endofpacket   = hold_single;
            // hold_empty - 4 reduces to its low two bits when hold_single is set
            out_empty         = hold_single ? hold_empty[1:0] : 2'd0;
            out_error         = hold_err;
         end
         S_LOW: begin
            out_valid         = 1'b1;
            out_data          = hold_data[31:0];
            out_endofpacket   = hold_eop;
            out_empty         = hold_eop ? hold_empty[1:0] : 2'd0;
            out_error         = hold_err;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_EMPTY;
         hold_data   <= '0;
         hold_sop    <= 1'b0;
         hold_eop    <= 1'b0;
         hold_single <= 1'b0;
         hold_empty  <= '0;
         hold_err    <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            hold_data   <= in_data;
            hold_sop    <= PKT && in_startofpacket;
            hold_eop    <= PKT && in_endofpacket;
            hold_single <= PKT && in_endofpacket && in_empty[2];
            hold_empty  <= PKT ? in_empty : 3'd0;
            hold_err    <= in_error;
         end
      end
   end

endmodule

// File: tb/tb_lcd_64_to_32_bits_adapter_core.sv
// Bench for the 64->32 adapter: a queue of expected words built from each accepted beat,
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_lcd_64_to_32_bits_adapter_core;

   typedef struct {
      logic [31:0] data;
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
      logic        err;
      logic        last;
   } word_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_startofpacket = 1'b0;
   logic        in_endofpacket = 1'b0;
   logic [2:0]  in_empty = '0;
   logic [0:0]  in_error = '0;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_startofpacket;
   logic        out_endofpacket;
   logic [1:0]  out_empty;
   logic [0:0]  out_error;

   int errors = 0;
   int checks = 0;
   int unsigned ready_pct = 100;

   word_t exp_q[$];
   word_t got_q[$];
   word_t ref_q[$];
   logic [36:0] prev_out;
   bit          stalled = 0;

   lcd_64_to_32_bits_adapter_core #(
      .USE_PACKETS(1),
      .ERROR_WIDTH(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_startofpacket(in_startofpacket),
      .in_endofpacket(in_endofpacket),
      .in_empty(in_empty),
      .in_error(in_error),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_startofpacket(out_startofpacket),
      .out_endofpacket(out_endofpacket),
      .out_empty(out_empty),
      .out_error(out_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      out_ready = ($urandom_range(99) < ready_pct);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [36:0] pack(input word_t w);
      return {w.data, w.sop, w.eop, w.empty, w.err};
   endfunction

   // Reference: one beat yields its high word, then its low word unless the
   // EOP beat leaves four or more symbols unused.
   task automatic model_beat(input logic [63:0] d, input logic s, input logic e,
                             input logic [2:0] em, input logic er);
      word_t w;
      bit short_tail;
      short_tail = e && (em >= 3'd4);
      w.data  = d[63:32];
      w.sop   = s;
      w.eop   = short_tail;
      w.empty = short_tail ? 2'(em - 3'd4) : 2'd0;
      w.err   = er;
      w.last  = short_tail;
      exp_q.push_back(w);
      if (!short_tail) begin
         w.data  = d[31:0];
         w.sop   = 1'b0;
         w.eop   = e;
         w.empty = e ? 2'(em % 4) : 2'd0;
         w.last  = 1'b1;
         exp_q.push_back(w);
      end
   endtask

   always @(negedge clk) begin
      word_t act;
      bit exp_rdy;
      act.data  = out_data;
      act.sop   = out_startofpacket;
      act.eop   = out_endofpacket;
      act.empty = out_empty;
      act.err   = out_error;
      act.last  = 1'b0;
      if (reset) begin
         exp_q.delete();
         stalled = 0;
      end else begin
         exp_rdy = (exp_q.size() == 0) || (out_ready && exp_q[0].last);
         chk("in_ready", 64'(in_ready), 64'(exp_rdy));
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         if (stalled) chk("stall_hold", 64'(pack(act)), 64'(prev_out));
         if (out_valid && exp_q.size() != 0) begin
            chk("word", 64'(pack(act)), 64'(pack(exp_q[0])));
            if (out_ready) begin
               got_q.push_back(act);
               void'(exp_q.pop_front());
            end
         end
         stalled  = out_valid && !out_ready;
         prev_out = pack(act);
         if (in_valid && in_ready)
            model_beat(in_data, in_startofpacket, in_endofpacket, in_empty, in_error);
      end
   end

   task automatic send_beat(input logic [63:0] d, input logic s, input logic e,
                            input logic [2:0] em, input logic er);
      int unsigned n = 0;
      bit done = 0;
      in_data = d;
      in_startofpacket = s;
      in_endofpacket = e;
      in_empty = em;
      in_error = er;
      in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready && !reset) done = 1;
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 300) begin
            chk("accept_timeout", 64'(n), 64'(0));
            done = 1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic stream4();
      send_beat(64'h0011223344556677, 1'b1, 1'b0, 3'd0, 1'b0);
      send_beat(64'h8899AABBCCDDEEFF, 1'b0, 1'b0, 3'd6, 1'b0);
      send_beat(64'h0123456789ABCDEF, 1'b0, 1'b0, 3'd0, 1'b0);
      send_beat(64'hFEDCBA9876543210, 1'b0, 1'b1, 3'd0, 1'b0);
      drain();
   endtask

   initial begin
      // 1: reset
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_in_ready", 64'(in_ready), 64'(1));
      chk("reset_out_data", 64'(out_data), 64'(0));
      @(posedge clk);
      #1;

      // 2: streaming, full rate
      ready_pct = 100;
      got_q.delete();
      stream4();
      chk("s2_count", 64'(got_q.size()), 64'(8));
      if (got_q.size() == 8) begin
         chk("s2_w0", 64'(pack(got_q[0])), 64'({32'h00112233, 1'b1, 1'b0, 2'd0, 1'b0}));
         chk("s2_w1", 64'(pack(got_q[1])), 64'({32'h44556677, 1'b0, 1'b0, 2'd0, 1'b0}));
         chk("s2_w7", 64'(pack(got_q[7])), 64'({32'h76543210, 1'b0, 1'b1, 2'd0, 1'b0}));
      end
      ref_q = got_q;

      // 3: short tail, then next beat
      got_q.delete();
      send_beat(64'hAABBCCDDEEFF0011, 1'b0, 1'b1, 3'd5, 1'b0);
      send_beat(64'h1122334455667788, 1'b1, 1'b1, 3'd0, 1'b0);
      drain();
      chk("s3_count", 64'(got_q.size()), 64'(3));
      if (got_q.size() == 3) begin
         chk("s3_w0", 64'(pack(got_q[0])), 64'({32'hAABBCCDD, 1'b0, 1'b1, 2'd1, 1'b0}));
         chk("s3_w1", 64'(pack(got_q[1])), 64'({32'h11223344, 1'b1, 1'b0, 2'd0, 1'b0}));
      end

      // 4: backpressure, output must match the unstalled run
      ready_pct = 30;
      got_q.delete();
      stream4();
      chk("s4_count", 64'(got_q.size()), 64'(ref_q.size()));
      for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
         chk("s4_same", 64'(pack(got_q[i])), 64'(pack(ref_q[i])));

      // 5: single-beat packet with error
      ready_pct = 100;
      got_q.delete();
      send_beat(64'hCAFEBABEDEADBEEF, 1'b1, 1'b1, 3'd2, 1'b1);
      drain();
      chk("s5_count", 64'(got_q.size()), 64'(2));
      if (got_q.size() == 2) begin
         chk("s5_w0", 64'(pack(got_q[0])), 64'({32'hCAFEBABE, 1'b1, 1'b0, 2'd0, 1'b1}));
         chk("s5_w1", 64'(pack(got_q[1])), 64'({32'hDEADBEEF, 1'b0, 1'b1, 2'd2, 1'b1}));
      end

      // 6: reset while the low word is stalled
      ready_pct = 0;
      send_beat(64'h5555666677778888, 1'b1, 1'b0, 3'd0, 1'b0);
      @(negedge clk);
      ready_pct = 100;
      @(negedge clk);
      ready_pct = 0;
      repeat (3) @(negedge clk);
      chk("s6_low_stalled", 64'(out_data), 64'(32'h77778888));
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("s6_out_valid", 64'(out_valid), 64'(0));
      got_q.delete();
      ready_pct = 100;
      @(posedge clk);
      #1;
      send_beat(64'h0F1E2D3C4B5A6978, 1'b1, 1'b1, 3'd0, 1'b0);
      drain();
      chk("s6_count", 64'(got_q.size()), 64'(2));
      if (got_q.size() == 2) begin
         chk("s6_w0", 64'(pack(got_q[0])), 64'({32'h0F1E2D3C, 1'b1, 1'b0, 2'd0, 1'b0}));
         chk("s6_w1", 64'(pack(got_q[1])), 64'({32'h4B5A6978, 1'b0, 1'b1, 2'd0, 1'b0}));
      end

      // random traffic
      ready_pct = 50;
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(2)) begin
            @(posedge clk);
            #1;
         end
         send_beat({$urandom, $urandom}, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
